// File: rtl/isp_pkg.sv
// Shared image-pipeline types: frame geometry defaults, coordinates, 3x3 window.
// No logic; constants, types and the RGB444-to-gray helper only.
// No flow control.
package isp_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int PIX_W_DEF = 12;
    localparam int XW        = 9;
    localparam int YW        = 8;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } coord_t;

    // w0 (top-left) sits in the least significant slot, w8 (bottom-right) in the most
    typedef logic [8:0][PIX_W_DEF-1:0] win_t;

    function automatic logic [PIX_W_DEF-1:0] to_gray(input logic [PIX_W_DEF-1:0] p);
        logic [5:0] s;
        s = 6'(p[11:8]) + 6'({p[7:4], 1'b0}) + 6'(p[3:0]);
        return {3{s[5:2]}};
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: simple dual-port RAM, one write and one registered read port.
// Latency: read data one cycle after rd_addr; writes land at the clock edge.
// No back-pressure; a write is taken whenever wr_vld is high.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int DW    = 12,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream; WIN_GRAY_EN selects gray conversion.
// Latency: o_valid one cycle after accepting pixel (x,y) with x>=2, y>=2.
// No back-pressure: one pixel per clock sustained, i_valid gaps simply hold the outputs.
module window_3x3_gen
    import isp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_sof,
    input  logic               i_valid,
    input  logic [PIX_W-1:0]   i_data,
    output logic               o_valid,
    output logic [9*PIX_W-1:0] o_win,
    output logic [XW-1:0]      o_cx,
    output logic [YW-1:0]      o_cy
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    coord_t          pos_q;
    coord_t          cur;
    coord_t          pos_nxt;
    logic            win_hit;
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] l1_dat;
    logic [PIX_W-1:0] l2_dat;
    win_t            win_q;

`ifdef WIN_GRAY_EN
    assign pix = to_gray(i_data);
`else
    assign pix = i_data;
`endif

    // A start-of-frame pulse retargets the current pixel (or the next one) to (0,0)
    assign cur     = i_sof ? '0 : pos_q;
    assign win_hit = i_valid && (cur.x >= XW'(2)) && (cur.y >= YW'(2));

    always_comb begin
        pos_nxt = cur;
        if (i_valid) begin
            if (cur.x == X_LAST) begin
                pos_nxt.x = '0;
                pos_nxt.y = (cur.y == Y_LAST) ? '0 : cur.y + 1'b1;
            end else begin
                pos_nxt.x = cur.x + 1'b1;
            end
        end
    end

    // Reads are issued one cycle ahead at the next column, so the registered read
    // data for column x is ready in the cycle that pixel x is accepted.
    line_buffer #(
        .DEPTH (IMG_W),
        .DW    (PIX_W),
        .AW    (AW)
    ) u_line1 (
        .clk     (clk),
        .wr_vld  (i_valid),
        .wr_addr (cur.x[AW-1:0]),
        .wr_dat  (pix),
        .rd_addr (pos_nxt.x[AW-1:0]),
        .rd_dat  (l1_dat)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .DW    (PIX_W),
        .AW    (AW)
    ) u_line2 (
        .clk     (clk),
        .wr_vld  (i_valid),
        .wr_addr (cur.x[AW-1:0]),
        .wr_dat  (l1_dat),
        .rd_addr (pos_nxt.x[AW-1:0]),
        .rd_dat  (l2_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q   <= '0;
            win_q   <= '0;
            o_valid <= 1'b0;
            o_cx    <= '0;
            o_cy    <= '0;
        end else begin
            pos_q   <= pos_nxt;
            o_valid <= win_hit;
            if (i_valid) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= l2_dat;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= l1_dat;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= pix;
            end
            if (win_hit) begin
                o_cx <= cur.x - 1'b1;
                o_cy <= cur.y - 1'b1;
            end
        end
    end

    assign o_win = win_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench: full-size ramp frame on a 320x240 instance, gaps/reset/sof/gray on a 10x8 instance.
module tb_window_3x3_gen;

    typedef struct packed {
        logic [8:0]   cx;
        logic [7:0]   cy;
        logic [107:0] win;
    } obs_t;

`ifdef WIN_GRAY_EN
    localparam logic [11:0] G0 = 12'h777;
`else
    localparam logic [11:0] G0 = 12'hF0F;
`endif
    localparam logic [11:0] G1 = 12'hFFF;
    localparam logic [11:0] G2 = 12'h000;

    logic         clk;
    logic         b_reset, b_sof, b_valid, b_ovalid;
    logic [11:0]  b_data;
    logic [107:0] b_win;
    logic [8:0]   b_cx;
    logic [7:0]   b_cy;
    logic         s_reset, s_sof, s_valid, s_ovalid;
    logic [11:0]  s_data;
    logic [107:0] s_win;
    logic [8:0]   s_cx;
    logic [7:0]   s_cy;

    int   errors = 0;
    int   checks = 0;
    obs_t obs_b[$];
    obs_t obs_s[$];

    window_3x3_gen u_big (
        .clk(clk), .reset(b_reset), .i_sof(b_sof), .i_valid(b_valid), .i_data(b_data),
        .o_valid(b_ovalid), .o_win(b_win), .o_cx(b_cx), .o_cy(b_cy)
    );

    window_3x3_gen #(.IMG_W(10), .IMG_H(8)) u_small (
        .clk(clk), .reset(s_reset), .i_sof(s_sof), .i_valid(s_valid), .i_data(s_data),
        .o_valid(s_ovalid), .o_win(s_win), .o_cx(s_cx), .o_cy(s_cy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b_ovalid === 1'b1) obs_b.push_back('{cx: b_cx, cy: b_cy, win: b_win});
        if (s_ovalid === 1'b1) obs_s.push_back('{cx: s_cx, cy: s_cy, win: s_win});
    end

    task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [11:0] pix_raw(input int v);
        return 12'(v % 4096);
    endfunction

    // Value the design is expected to store/output for a given raw input
    function automatic logic [11:0] pix_of(input int v);
        logic [11:0] p;
        p = pix_raw(v);
`ifdef WIN_GRAY_EN
        begin
            int s;
            s = (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) >> 2;
            p = {3{4'(s)}};
        end
`endif
        return p;
    endfunction

    function automatic logic [107:0] ramp_win(input int w, input int off, input int cx, input int cy);
        logic [107:0] r;
        r = '0;
        for (int row = 0; row < 3; row++)
            for (int col = 0; col < 3; col++)
                r[(row*3+col)*12 +: 12] = pix_of((cy - 1 + row) * w + (cx - 1 + col) + off);
        return r;
    endfunction

    task automatic drive_b(input logic sof, input logic [11:0] d);
        b_sof = sof; b_valid = 1'b1; b_data = d;
        @(posedge clk); #1;
        b_sof = 1'b0; b_valid = 1'b0;
    endtask

    task automatic drive_s(input logic sof, input logic [11:0] d);
        s_sof = sof; s_valid = 1'b1; s_data = d;
        @(posedge clk); #1;
        s_sof = 1'b0; s_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] gtbl [3];
        obs_t want;
        int   bad;
        int   k;

        gtbl[0] = 12'hF0F; gtbl[1] = 12'hFFF; gtbl[2] = 12'h000;
        b_reset = 1'b0; b_sof = 1'b0; b_valid = 1'b0; b_data = '0;
        s_reset = 1'b0; s_sof = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_b_valid", b_ovalid, 0);
        chk("rst_b_win", b_win, 0);
        chk("rst_b_cx", b_cx, 0);
        chk("rst_b_cy", b_cy, 0);
        chk("rst_s_valid", s_ovalid, 0);
        chk("rst_s_win", s_win, 0);
        b_reset = 1'b1; s_reset = 1'b1;
        idle();

        // Full-rate 320x240 ramp frame
        for (int v = 0; v < 76800; v++) begin
            drive_b(v == 0, pix_raw(v));
            if (v == 641) chk("b_pre_first_valid", b_ovalid, 0);
            if (v == 642) begin
                chk("b_first_valid", b_ovalid, 1);
                chk("b_first_cx", b_cx, 1);
                chk("b_first_cy", b_cy, 1);
                chk("b_first_win", b_win, ramp_win(320, 0, 1, 1));
            end
        end
        idle();
        chk("b_hold_valid", b_ovalid, 0);
        chk("b_last_cx", b_cx, 318);
        chk("b_last_cy", b_cy, 238);
        chk("b_last_w8", b_win[107:96], pix_of(3071));
        chk("b_window_count", obs_b.size(), 75684);
        bad = 0; k = 0;
        for (int cy = 1; cy <= 238; cy++)
            for (int cx = 1; cx <= 318; cx++) begin
                want = '{cx: 9'(cx), cy: 8'(cy), win: ramp_win(320, 0, cx, cy)};
                if (k >= obs_b.size() || obs_b[k] !== want) bad++;
                k++;
            end
        chk("b_window_seq", bad, 0);

        // 10x8 ramp frame with irregular input gaps
        for (int v = 0; v < 80; v++) begin
            while ($urandom_range(0, 9) < 3) idle();
            drive_s(v == 0, pix_raw(v));
        end
        repeat (3) idle();
        chk("s_gap_count", obs_s.size(), 48);
        bad = 0; k = 0;
        for (int cy = 1; cy <= 6; cy++)
            for (int cx = 1; cx <= 8; cx++) begin
                want = '{cx: 9'(cx), cy: 8'(cy), win: ramp_win(10, 0, cx, cy)};
                if (k >= obs_s.size() || obs_s[k] !== want) bad++;
                k++;
            end
        chk("s_gap_seq", bad, 0);
        chk("s_gap_hold_cx", s_cx, 8);
        chk("s_gap_hold_cy", s_cy, 6);

        // Column pattern F0F/FFF/000 through both line buffers
        for (int v = 0; v <= 22; v++) drive_s(v == 0, gtbl[(v % 10) % 3]);
        chk("s_gray_valid", s_ovalid, 1);
        chk("s_gray_win", s_win, {G2, G1, G0, G2, G1, G0, G2, G1, G0});

        // Reset at (5,4), then a new frame without sof and with distinct data
        for (int v = 0; v <= 45; v++) drive_s(v == 0, pix_raw(v));
        s_reset = 1'b0;
        #1;
        chk("s_midrst_valid", s_ovalid, 0);
        chk("s_midrst_win", s_win, 0);
        chk("s_midrst_cx", s_cx, 0);
        chk("s_midrst_cy", s_cy, 0);
        @(posedge clk); #1;
        s_reset = 1'b1;
        obs_s.delete();
        for (int v = 0; v <= 21; v++) drive_s(1'b0, pix_raw(v + 100));
        chk("s_postrst_early", obs_s.size(), 0);
        drive_s(1'b0, pix_raw(122));
        chk("s_postrst_valid", s_ovalid, 1);
        chk("s_postrst_cx", s_cx, 1);
        chk("s_postrst_cy", s_cy, 1);
        chk("s_postrst_win", s_win, ramp_win(10, 100, 1, 1));

        // Start-of-frame at (6,5) restarts the frame at that pixel
        for (int v = 23; v <= 55; v++) drive_s(1'b0, pix_raw(v + 100));
        drive_s(1'b1, pix_raw(200));
        chk("s_sof_valid", s_ovalid, 0);
        obs_s.delete();
        for (int v = 1; v <= 21; v++) drive_s(1'b0, pix_raw(v + 200));
        chk("s_sof_early", obs_s.size(), 0);
        drive_s(1'b0, pix_raw(222));
        chk("s_sof_first_valid", s_ovalid, 1);
        chk("s_sof_first_cx", s_cx, 1);
        chk("s_sof_first_cy", s_cy, 1);
        chk("s_sof_first_win", s_win, ramp_win(10, 200, 1, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
